// File: rtl/sram_controller.sv
// sram_controller: 32-bit MEM-stage load/store port onto a 16-bit SRAM, two half-word accesses per request.
// Optional SRAM_RANGE_CHECK_EN flags addresses outside the 512 KiB data window instead of wrapping.
module sram_controller #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        err,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  localparam logic [3:0]  LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [31:0] BASE = 32'd1024;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [31:0] w_off;
  logic        w_req;
  logic        w_last;
  logic        w_oor;
  logic        w_accept;
  logic        w_unused;

  assign w_req    = wr_en | rd_en;
  assign w_off    = address - BASE;
  assign w_last   = (r_cnt == LAST);
  assign w_accept = (r_state == S_IDLE) && w_req;
  assign w_unused = ^{w_off[31:19], w_off[1:0]};
  assign readData = r_rdata;

`ifdef SRAM_RANGE_CHECK_EN
  logic r_err;

  assign w_oor = (address < BASE) ||
                 (address >= BASE + 32'h0008_0000);
  assign err   = (r_state == S_DONE) && r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_oor;
    end
  end
`else
  assign w_oor = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next = w_oor ? S_DONE : S_LOW;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_next = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // counter restarts on every state entry and idles at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) ||
                 (r_state == S_IDLE) ||
                 (r_state == S_DONE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= wr_en;
      r_word  <= w_off[18:2];
      r_wdata <= writeData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (!r_wr && w_last) begin
      if (r_state == S_LOW) begin
        r_rdata[15:0] <= sram_dq_in;
      end
      if (r_state == S_HIGH) begin
        r_rdata[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    case (r_state)
      S_IDLE: ready = !w_req;
      S_LOW: begin
        sram_addr  = {r_word, 1'b0};
        sram_we_n  = !r_wr;
        sram_dq_oe = r_wr;
        if (r_wr) begin
          sram_dq_out = r_wdata[15:0];
        end
      end
      S_HIGH: begin
        sram_addr  = {r_word, 1'b1};
        sram_we_n  = !r_wr;
        sram_dq_oe = r_wr;
        if (r_wr) begin
          sram_dq_out = r_wdata[31:16];
        end
      end
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 3, meaning SRAM clock cycles spent on each 16-bit half-word access (legal range 1..15).
REQ-002 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port wr_en, input, 1 bit: write request from the MEM stage, held until ready.
REQ-005 Port rd_en, input, 1 bit: read request from the MEM stage, held until ready.
REQ-006 Port address, input, 32 bits: byte address (ALU result); data region base is 1024.
REQ-007 Port writeData, input, 32 bits: store data (Val_Rm).
REQ-008 Port readData, output, 32 bits: registered load data.
REQ-009 Port ready, output, 1 bit: low while a request is in progress; the pipeline freezes on ready=0.
REQ-010 Port err, output, 1 bit: out-of-range access flag, valid while ready=1 in DONE.
REQ-011 Port sram_addr, output, 18 bits: half-word address.
REQ-012 Port sram_we_n, output, 1 bit: active-low SRAM write strobe.
REQ-013 Port sram_dq_out, output, 16 bits: write data.
REQ-014 Port sram_dq_oe, output, 1 bit: data-bus drive enable.
REQ-015 Port sram_dq_in, input, 16 bits: read data.

Function
REQ-016 The FSM SHALL have states IDLE, LOW, HIGH and DONE.
REQ-017 IDLE SHALL accept a request when wr_en|rd_en=1, latch op/address/writeData and go to LOW; wr_en SHALL win if both are set.
REQ-018 LOW and HIGH SHALL each last exactly ACCESS_CYCLES cycles, timed by a 4-bit counter cleared on every state entry.
REQ-019 HIGH SHALL go to DONE, and DONE SHALL go to IDLE unconditionally after 1 cycle.
REQ-020 ready SHALL be combinational: 1 in IDLE with no request, 0 in IDLE with a request, 0 in LOW/HIGH, 1 in DONE.
REQ-021 Latency from accept edge to the ready=1 cycle SHALL be 2*ACCESS_CYCLES+1 cycles.
REQ-022 A request held across DONE→IDLE SHALL be treated as a new request; the MEM stage advances on the DONE edge.
REQ-023 word index SHALL equal (address-1024)[18:2] (17 bits).
REQ-024 sram_addr SHALL be {word,0} in LOW and {word,1} in HIGH, and 0 otherwise.
REQ-025 Writes SHALL drive sram_dq_out=writeData[15:0] in LOW and [31:16] in HIGH, with sram_dq_oe=1 and sram_we_n=0 throughout LOW/HIGH.
REQ-026 Reads SHALL keep sram_we_n=1 and sram_dq_oe=0.
REQ-027 On reads, sram_dq_in SHALL be captured into readData[15:0] on the last LOW cycle and into [31:16] on the last HIGH cycle.
REQ-028 readData SHALL hold its value until the next read's capture, and writes SHALL NOT alter it.
REQ-029 Address bits [1:0] SHALL be ignored (word aligned).

Reset
REQ-030 While rst=0 the block SHALL force state=IDLE, counter=0, readData=0, err=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0 and sram_dq_out=0.
REQ-031 On reset mid-transfer, the transfer SHALL be abandoned immediately, with no further SRAM strobe.
REQ-032 Reset release SHALL be followed by IDLE with ready=1 (given no request).

Configuration
REQ-033 Macro SRAM_RANGE_CHECK_EN, when defined, SHALL flag as out of range any address <1024 or >=1024+2^19.
REQ-034 An out-of-range access SHALL go IDLE→DONE directly, with no SRAM strobe and readData unchanged.
REQ-035 err SHALL be 1 during that DONE cycle and 0 otherwise.
REQ-036 Without the macro, err SHALL be tied 0 and out-of-range addresses SHALL wrap modulo 2^19 bytes with full timing.

Verification
REQ-037 Write 0xDEADBEEF to 1028 with ACCESS_CYCLES=3 -> sram_addr=2 with dq 0xBEEF for 3 cycles, then sram_addr=3 with dq 0xDEAD for 3 cycles, and ready=1 on cycle 7.
REQ-038 Read of 1028 with the SRAM model returning 0xBEEF/0xDEAD -> readData=0xDEADBEEF when ready=1, and sram_we_n stays 1.
REQ-039 wr_en=rd_en=1 at 1024 -> write performed (sram_we_n=0), and readData keeps its prior value.
REQ-040 rst=0 asserted in cycle 2 of HIGH -> sram_we_n=1 and sram_dq_oe=0 immediately, and ready=1 after release.
REQ-041 Back-to-back reads at 1024 then 1032 with requests held -> two 7-cycle transactions, separated only by the DONE→IDLE→accept sequence.
REQ-042 With SRAM_RANGE_CHECK_EN, read of address 512 -> ready=1 one cycle after accept, err=1 and no SRAM strobe; without the macro, err=0 and full 7-cycle timing.
